video_ram_arb: RTL and testbench
================================

# video_ram_arb

Parametrised single-port video RAM with three clients: a display scan-out read port, a host read/write port with request/acknowledge handshake, and a built-in fill engine for clearing the screen. One array access per clock, in fixed priority order display > host > fill. Pipelined read path with 2-cycle latency, so the display side sees a constant-latency stream. Sits between the CPU/bus bridge and the video timing generator.

## Interface
- DATA_W, 8, word width in bits (1..36)
- ADDR_W, 11, address width; depth = 2^ADDR_W words
- INIT_FILE, "", hex image loaded at configuration; empty = contents undefined
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  display read request, sampled every edge
- vid_addr  in  ADDR_W  display read address
- vid_data  out  DATA_W  display read data
- vid_valid  out  1  vid_data valid this cycle
- host_req  in  1  host request; held with stable host_we/addr/wdata until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle pulse: request granted this edge
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid this cycle (reads only)
- fill_start  in  1  one-cycle pulse: write fill_value to every address
- fill_value  in  DATA_W  fill word, captured at fill_start
- fill_busy  out  1  fill in progress

## Operation
- Arbiter, per edge, exactly one grant: vid_req → display read; else host_req (and not fill_busy) → host access; else fill_busy → fill write; else idle.
- Display always granted; never stalls, never dropped.
- Host: granted edge raises host_ack for one cycle; host may change/drop host_req the cycle after ack. host_req while fill_busy is held off (no ack) until fill done.
- Fill engine: states IDLE, RUN. IDLE + fill_start → RUN, capture fill_value, counter=0, fill_busy=1. In RUN, each granted fill slot writes value to counter, counter+1. Write to address 2^ADDR_W−1 → IDLE, fill_busy=0 on that same edge. fill_start in RUN ignored.
- Read pipeline: 2-stage tag shift register (none/vid/host) follows array address/data registers; output register is routed by tag. vid_data / host_rdata hold last value when their valid is low. Writes never produce a valid or disturb data outputs.
- Same-address ordering: accesses complete in grant order; a read granted after a write to the same address returns the new data.
- Reset (any time, including mid-fill or with reads in flight): fill_busy=0, FSM IDLE, counter 0, pipeline tags cleared, vid_valid=0, host_ack=0, host_rvalid=0, vid_data=0, host_rdata=0. Array contents not cleared; in-flight read results discarded.

## Timing
- Display read sampled at edge k → vid_valid=1, vid_data valid after edge k+2. Back-to-back vid_req gives continuous vid_valid stream, one word per cycle.
- Host ack after grant edge g; read data host_rvalid after edge g+2. Minimum host turnaround: ack at g, next request can be granted at g+1.
- Host wait unbounded while vid_req continuous or fill running; no starvation guard by design.
- Fill duration with no other traffic: 2^ADDR_W cycles from fill_start edge to fill_busy fall; each display/host slot during fill extends it by 1 cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then host write 0xA5 @0x123, host read @0x123 → host_ack pulses each, host_rvalid 2 edges after read grant with host_rdata=0xA5; vid_valid stays 0.
- vid_req held 16 cycles reading 0..15 while host_req pending → no host_ack during the burst, vid_valid continuous with correct data, host_ack on first edge after vid_req drops.
- fill_start with value 0x3C, ADDR_W=4 → fill_busy 16 cycles, then display sweep of all 16 addresses returns 0x3C; host_req during fill acked only after fill_busy falls.
- Fill with interleaved vid_req every 3rd cycle → fill_busy lengthened by exact count of display grants; display data during fill is old or 0x3C per address order.
- Host write 0x11 @7 granted at g, vid_req @7 at g+1 → vid_data=0x11 at g+3.
- reset_n asserted mid-fill with display reads in flight → all valids/busy 0 immediately; after release, fill_start restarts from address 0.

Source files
------------

// File: rtl/video_ram_arb.sv
// Single-port video RAM: display > host > fill priority, one array access per clock.
// Reads return 2 cycles after grant; display never stalls, host waits for host_ack, fill yields its slots.
module video_ram_arb #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_IDLE, S_RUN} fill_state_e;
    typedef enum logic [1:0] {T_NONE, T_VID, T_HOST} tag_e;

    logic [DATA_W-1:0] mem [DEPTH];

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fval_q, fval_d;

    logic gnt_vid, gnt_host, gnt_fill;

    tag_e              s1_tag_q, s1_tag_d;
    logic              s1_we_q, s1_we_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;
    tag_e              s2_tag_q;
    logic [DATA_W-1:0] rd_q;

    logic [DATA_W-1:0] vid_data_q, host_rdata_q;
    logic              vid_valid_q, host_rvalid_q, host_ack_q;

    assign fill_busy = (state_q == S_RUN);
    assign gnt_vid   = vid_req;
    assign gnt_host  = !vid_req && host_req && !fill_busy;
    assign gnt_fill  = !vid_req && !gnt_host && fill_busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fval_d  = fval_q;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    fval_d  = fill_value;
                end
            end
            S_RUN: begin
                if (gnt_fill) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (&cnt_q) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s1_tag_d   = T_NONE;
        s1_we_d    = 1'b0;
        s1_addr_d  = s1_addr_q;
        s1_wdata_d = s1_wdata_q;
        if (gnt_vid) begin
            s1_tag_d  = T_VID;
            s1_addr_d = vid_addr;
        end else if (gnt_host) begin
            s1_tag_d   = host_we ? T_NONE : T_HOST;
            s1_we_d    = host_we;
            s1_addr_d  = host_addr;
            s1_wdata_d = host_wdata;
        end else if (gnt_fill) begin
            s1_we_d    = 1'b1;
            s1_addr_d  = cnt_q;
            s1_wdata_d = fval_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            fval_q        <= '0;
            s1_tag_q      <= T_NONE;
            s1_we_q       <= 1'b0;
            s1_addr_q     <= '0;
            s1_wdata_q    <= '0;
            s2_tag_q      <= T_NONE;
            vid_data_q    <= '0;
            vid_valid_q   <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            host_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fval_q        <= fval_d;
            s1_tag_q      <= s1_tag_d;
            s1_we_q       <= s1_we_d;
            s1_addr_q     <= s1_addr_d;
            s1_wdata_q    <= s1_wdata_d;
            s2_tag_q      <= s1_tag_q;
            host_ack_q    <= gnt_host;
            vid_valid_q   <= (s2_tag_q == T_VID);
            host_rvalid_q <= (s2_tag_q == T_HOST);
            if (s2_tag_q == T_VID)  vid_data_q   <= rd_q;
            if (s2_tag_q == T_HOST) host_rdata_q <= rd_q;
        end
    end

    // Array port sits one edge behind the grant, so accesses stay in grant order.
    always_ff @(posedge clk) begin
        if (s1_we_q) mem[s1_addr_q] <= s1_wdata_q;
        else         rd_q           <= mem[s1_addr_q];
    end

    assign vid_data    = vid_data_q;
    assign vid_valid   = vid_valid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_ack    = host_ack_q;

endmodule

// File: tb/tb_video_ram_arb.sv
// Randomised and directed checks of video_ram_arb against a grant-order memory model.
module tb_video_ram_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vid_req, host_req, host_we, fill_start;
  logic [3:0] vid_addr, host_addr;
  logic [7:0] host_wdata, fill_value;
  logic [7:0] vid_data, host_rdata;
  logic       vid_valid, host_ack, host_rvalid, fill_busy;

  video_ram_arb #(.DATA_W(8), .ADDR_W(4), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [7:0] d; bit k;} exp_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] m_mem [16];
  bit         m_known [16];
  bit         m_busy = 0;
  int         m_cnt = 0;
  logic [7:0] m_val = 0;
  exp_t       vq[$];
  exp_t       hq[$];
  logic [7:0] lv = 0, lh = 0;
  bit         lvk = 1, lhk = 1;
  bit         g_vid_last, g_host_last, busy_pre_last;
  bit         last_wr = 0;
  int         last_wr_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vid_valid"}, vid_valid, 0);
    chk({tag, "_host_ack"}, host_ack, 0);
    chk({tag, "_host_rvalid"}, host_rvalid, 0);
    chk({tag, "_vid_data"}, vid_data, 0);
    chk({tag, "_host_rdata"}, host_rdata, 0);
    chk({tag, "_fill_busy"}, fill_busy, 0);
  endtask

  // One clock: apply the priority rule to the inputs seen at the edge, then check outputs.
  task automatic step();
    bit   gv, gh, gf, was_busy;
    exp_t e;
    @(posedge clk);
    cyc++;
    was_busy = m_busy;
    gv = vid_req;
    gh = !gv && host_req && !m_busy;
    gf = !gv && !gh && m_busy;
    last_wr = 0;
    if (gv) vq.push_back('{cyc + 2, m_mem[vid_addr], m_known[vid_addr]});
    if (gh) begin
      if (host_we) begin
        m_mem[host_addr] = host_wdata;
        m_known[host_addr] = 1;
        last_wr = 1;
        last_wr_addr = int'(host_addr);
      end else begin
        hq.push_back('{cyc + 2, m_mem[host_addr], m_known[host_addr]});
      end
    end
    if (gf) begin
      m_mem[m_cnt] = m_val;
      m_known[m_cnt] = 1;
      last_wr = 1;
      last_wr_addr = m_cnt;
      if (m_cnt == 15) m_busy = 0;
      m_cnt = (m_cnt + 1) % 16;
    end
    if (!was_busy && fill_start) begin
      m_busy = 1;
      m_cnt = 0;
      m_val = fill_value;
    end
    g_vid_last = gv;
    g_host_last = gh;
    busy_pre_last = was_busy;
    #1;
    chk("host_ack", host_ack, gh);
    chk("fill_busy", fill_busy, m_busy);
    if (vq.size() > 0 && vq[0].due == cyc) begin
      e = vq.pop_front();
      chk("vid_valid", vid_valid, 1);
      if (e.k) chk("vid_data", vid_data, e.d);
      lv = e.d; lvk = e.k;
    end else begin
      chk("vid_valid_idle", vid_valid, 0);
      if (lvk) chk("vid_data_hold", vid_data, lv);
    end
    if (hq.size() > 0 && hq[0].due == cyc) begin
      e = hq.pop_front();
      chk("host_rvalid", host_rvalid, 1);
      if (e.k) chk("host_rdata", host_rdata, e.d);
      lh = e.d; lhk = e.k;
    end else begin
      chk("host_rvalid_idle", host_rvalid, 0);
      if (lhk) chk("host_rdata_hold", host_rdata, lh);
    end
    if (gh) host_req = 0;
    fill_start = 0;
  endtask

  task automatic host_do(input bit we, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    do begin step(); n++; end while (!g_host_last && n < 300);
    chk("host_ack_wait", host_ack, 1);
  endtask

  task automatic do_reset();
    vid_req = 0; host_req = 0; fill_start = 0;
    reset_n = 0;
    #1;
    if (last_wr) m_known[last_wr_addr] = 0;
    last_wr = 0;
    vq.delete(); hq.delete();
    m_busy = 0; m_cnt = 0;
    lv = 0; lh = 0; lvk = 1; lhk = 1;
    check_zero("rst_now");
    @(posedge clk); @(posedge clk); #1;
    check_zero("rst_hold");
    reset_n = 1;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  initial begin
    int bc, vg, n;
    for (int i = 0; i < 16; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    reset_n = 0; vid_req = 0; host_req = 0; host_we = 0; fill_start = 0;
    vid_addr = 0; host_addr = 0; host_wdata = 0; fill_value = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1;

    // host write then read back at the same address
    host_do(1, 4'h3, 8'hA5);
    host_do(0, 4'h3, 8'h00);
    drain();

    // display burst with a host read pending
    host_req = 1; host_we = 0; host_addr = 4'h3;
    for (int i = 0; i < 16; i++) begin vid_req = 1; vid_addr = 4'(i); step(); end
    vid_req = 0;
    step();
    chk("ack_after_burst", host_ack, 1);
    drain();

    // screen fill, host write held off until done
    fill_value = 8'h3C; fill_start = 1;
    step();
    bc = (fill_busy === 1'b1) ? 1 : 0;
    host_req = 1; host_we = 1; host_addr = 4'h5; host_wdata = 8'h77;
    n = 0;
    while (m_busy && n < 100) begin step(); n++; if (fill_busy === 1'b1) bc++; end
    chk("fill_len", bc, 16);
    step();
    chk("host_ack_after_fill", host_ack, 1);
    for (int i = 0; i < 16; i++) begin vid_req = 1; vid_addr = 4'(i); step(); end
    vid_req = 0;
    drain();

    // fill with a display read every third cycle
    fill_value = 8'(($urandom % 255) + 1); fill_start = 1;
    vid_req = 0;
    step();
    bc = (fill_busy === 1'b1) ? 1 : 0;
    vg = 0; n = 0;
    while (m_busy && n < 200) begin
      vid_req = (n % 3 == 2); vid_addr = 4'($urandom % 16);
      step();
      if (g_vid_last && busy_pre_last) vg++;
      if (fill_busy === 1'b1) bc++;
      n++;
    end
    vid_req = 0;
    chk("fill_len_interleaved", bc, 16 + vg);
    drain();

    // write followed immediately by a display read of the same word
    host_do(1, 4'h7, 8'h11);
    vid_req = 1; vid_addr = 4'h7;
    step();
    vid_req = 0;
    step(); step();
    chk("raw_vid_valid", vid_valid, 1);
    chk("raw_vid_data", vid_data, 8'h11);
    drain();

    // random mixed traffic
    for (int i = 0; i < 400; i++) begin
      vid_req = ($urandom % 5) < 2; vid_addr = 4'($urandom % 16);
      if (!host_req && ($urandom % 3) == 0) begin
        host_req = 1; host_we = $urandom % 2;
        host_addr = 4'($urandom % 16); host_wdata = 8'($urandom);
      end
      if (($urandom % 80) == 0) begin fill_start = 1; fill_value = 8'($urandom); end
      step();
    end
    vid_req = 0; host_req = 0;
    n = 0;
    while (m_busy && n < 100) begin step(); n++; end
    drain();

    // reset mid-fill with display reads in flight, then refill from address 0
    fill_value = 8'h5A; fill_start = 1;
    step();
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin vid_req = 1; vid_addr = 4'(i); step(); end
    do_reset();
    fill_value = 8'hC3; fill_start = 1;
    step();
    bc = (fill_busy === 1'b1) ? 1 : 0;
    n = 0;
    while (m_busy && n < 100) begin step(); n++; if (fill_busy === 1'b1) bc++; end
    chk("refill_len", bc, 16);
    for (int i = 0; i < 16; i++) begin vid_req = 1; vid_addr = 4'(i); step(); end
    vid_req = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
